// File: rtl/shift_pkg.sv
// Shared types and constants for the sequenced shift arbiter.
package shift_pkg;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = 3;

  typedef enum logic [1:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR} shop_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [SW-1:0] MAX_STEP = 3'd7;

  // Positions the shifter can cover in one pass for a given remaining amount.
  function automatic logic [SW-1:0] step_of(input logic [AW-1:0] rem);
    return (rem > AW'(MAX_STEP)) ? MAX_STEP : rem[SW-1:0];
  endfunction

endpackage

// File: rtl/shifter.sv
// Existing 8-bit barrel shifter: all four shift flavours by a 3-bit amount.
module shifter
  import shift_pkg::*;
(
  input  logic [DW-1:0] a_i,
  input  logic [SW-1:0] amt_i,
  output logic [DW-1:0] lsl_o,
  output logic [DW-1:0] lsr_o,
  output logic [DW-1:0] asr_o,
  output logic [DW-1:0] ror_o
);

  assign lsl_o = a_i << amt_i;
  assign lsr_o = a_i >> amt_i;
  assign asr_o = DW'($signed(a_i) >>> amt_i);
  // With amt 0 the left term shifts out completely, leaving a unchanged.
  assign ror_o = (a_i >> amt_i) | (a_i << (AW'(DW) - AW'(amt_i)));

endmodule

// File: rtl/shift_arbiter_seq.sv
// Round-robin arbiter sharing one shifter between two requesters, extending
// the shift range to 0-15 by chaining passes of at most 7 positions.
module shift_arbiter_seq
  import shift_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [1:0]    req0_op,
  input  logic [AW-1:0] req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [1:0]    req1_op,
  input  logic [AW-1:0] req1_amt,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_y
);

  state_t        state_q;
  logic [DW-1:0] acc_q;
  logic [AW-1:0] rem_q;
  shop_t         op_q;
  logic          id_q;
  logic          last_grant_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_y_q;

  logic          grant_c;
  logic          arb_en_c;
  logic          accept_c;
  logic [DW-1:0] a_sel_c;
  logic [1:0]    op_sel_c;
  logic [AW-1:0] amt_sel_c;
  logic [SW-1:0] step_c;
  logic [AW-1:0] rem_d;
  logic [DW-1:0] shift_y_c;
  logic [DW-1:0] lsl_c, lsr_c, asr_c, ror_c;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign arb_en_c   = (state_q == S_IDLE) && !reset;
  assign req0_ready = arb_en_c && req0_valid && !grant_c;
  assign req1_ready = arb_en_c && req1_valid && grant_c;
  assign accept_c   = req0_ready || req1_ready;

  assign a_sel_c   = grant_c ? req1_a   : req0_a;
  assign op_sel_c  = grant_c ? req1_op  : req0_op;
  assign amt_sel_c = grant_c ? req1_amt : req0_amt;

  assign step_c = step_of(rem_q);
  assign rem_d  = rem_q - AW'(step_c);

  shifter u_shifter (
    .a_i   (acc_q),
    .amt_i (step_c),
    .lsl_o (lsl_c),
    .lsr_o (lsr_c),
    .asr_o (asr_c),
    .ror_o (ror_c)
  );

  always_comb begin
    shift_y_c = lsl_c;
    case (op_q)
      OP_LSL:  shift_y_c = lsl_c;
      OP_LSR:  shift_y_c = lsr_c;
      OP_ASR:  shift_y_c = asr_c;
      OP_ROR:  shift_y_c = ror_c;
      default: shift_y_c = lsl_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      op_q         <= OP_LSL;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_y_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            acc_q        <= a_sel_c;
            op_q         <= shop_t'(op_sel_c);
            rem_q        <= amt_sel_c;
            id_q         <= grant_c;
            last_grant_q <= grant_c;
            state_q      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc_q <= shift_y_c;
          rem_q <= rem_d;
          if (rem_d == '0) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_y_q     <= shift_y_c;
            rsp_id_q    <= id_q;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Directed bench for shift_arbiter_seq with hand-computed results and latencies.
module tb_shift_arbiter_seq;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req1_a;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_amt, req1_amt;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_y;

  int n_chk  = 0;
  int n_pass = 0;

  shift_arbiter_seq dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_op    (req0_op),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_op    (req1_op),
    .req1_amt   (req1_amt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Requesters must hold valid and fields until accepted.
  a_hold0: assert property (@(posedge clk) disable iff (reset)
    (req0_valid && !req0_ready) |=>
      (req0_valid && $stable(req0_a) && $stable(req0_op) && $stable(req0_amt)))
    else $error("FAIL req0 hold: valid or fields changed before ready");
  a_hold1: assert property (@(posedge clk) disable iff (reset)
    (req1_valid && !req1_ready) |=>
      (req1_valid && $stable(req1_a) && $stable(req1_op) && $stable(req1_amt)))
    else $error("FAIL req1 hold: valid or fields changed before ready");

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_req(input logic id, input logic [7:0] a, input logic [1:0] op,
                           input logic [3:0] amt);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_op = op; req1_amt = amt;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_op = op; req0_amt = amt;
    end
  endtask

  // Counts negedges after an accept edge until rsp_valid; 0 means timeout.
  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) check({tag, " timeout"}, 32'(rsp_valid), 32'd1);
  endtask

  // Single-requester transaction; entered 1ns after a posedge with the DUT idle.
  task automatic run_txn(input logic id, input logic [7:0] a, input logic [1:0] op,
                         input logic [3:0] amt, input logic [7:0] exp_y,
                         input int exp_lat, input string tag);
    int n;
    drive_req(id, a, op, amt);
    @(negedge clk);
    check({tag, " ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    @(posedge clk); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    wait_rsp(tag, n);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " y"}, 32'(rsp_y), 32'(exp_y));
    check({tag, " id"}, 32'(rsp_id), 32'(id));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int  n;
    logic exp_id;
    logic saw_rsp;
    reset = 1'b1;
    rsp_ready = 1'b1;
    req1_valid = 1'b0; req1_a = '0; req1_op = '0; req1_amt = '0;
    drive_req(1'b0, 8'h96, OP_ROR, 4'd3);

    // Reset state; a request raised during reset is not accepted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready0", 32'(req0_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_y", 32'(rsp_y), 32'h00);
    check("rst rsp_id", 32'(rsp_id), 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    run_txn(1'b0, 8'h96, OP_ROR, 4'd3,  8'hD2, 2, "ror3");
    run_txn(1'b1, 8'h80, OP_ASR, 4'd15, 8'hFF, 4, "asr15");
    run_txn(1'b0, 8'h01, OP_LSL, 4'd7,  8'h80, 2, "lsl7");
    run_txn(1'b0, 8'h01, OP_LSL, 4'd8,  8'h00, 3, "lsl8");
    run_txn(1'b1, 8'h5A, OP_ROR, 4'd0,  8'h5A, 2, "ror0");
    run_txn(1'b1, 8'hF0, OP_LSR, 4'd4,  8'h0F, 2, "lsr4");
    run_txn(1'b0, 8'h40, OP_ASR, 4'd9,  8'h00, 3, "asr9");
    run_txn(1'b0, 8'hC0, OP_ASR, 4'd7,  8'hFF, 2, "asr7");
    run_txn(1'b0, 8'h80, OP_LSR, 4'd15, 8'h00, 4, "lsr15");
    run_txn(1'b1, 8'h81, OP_ROR, 4'd12, 8'h18, 3, "ror12");

    // Both requesters continuously valid: grants alternate starting with req0.
    drive_req(1'b0, 8'h01, OP_LSL, 4'd1);
    drive_req(1'b1, 8'h80, OP_LSR, 4'd1);
    exp_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
      end
      check("alt any ready", 32'(req0_ready | req1_ready), 32'd1);
      check("alt ready1", 32'(req1_ready), 32'(exp_id));
      check("alt ready0", 32'(req0_ready), 32'(!exp_id));
      @(posedge clk); #1;
      if (k >= 4) begin
        if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      end
      wait_rsp("alt", n);
      check("alt rsp_id", 32'(rsp_id), 32'(exp_id));
      check("alt rsp_y", 32'(rsp_y), exp_id ? 32'h40 : 32'h02);
      exp_id = ~exp_id;
      @(posedge clk); #1;
    end

    // Back-pressure: response holds and nothing is accepted while blocked.
    do_reset();
    rsp_ready = 1'b0;
    drive_req(1'b0, 8'hF0, OP_LSR, 4'd4);
    drive_req(1'b1, 8'h81, OP_ROR, 4'd12);
    @(negedge clk);
    check("bp tie ready0", 32'(req0_ready), 32'd1);
    check("bp tie ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp("bp", n);
    check("bp latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", 32'(rsp_valid), 32'd1);
      check("bp hold y", 32'(rsp_y), 32'h0F);
      check("bp hold id", 32'(rsp_id), 32'd0);
      check("bp hold ready1", 32'(req1_ready), 32'd0);
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release valid", 32'(rsp_valid), 32'd0);
    check("bp release ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp("bp2", n);
    check("bp2 latency", 32'(n), 32'd3);
    check("bp2 y", 32'(rsp_y), 32'h18);
    check("bp2 id", 32'(rsp_id), 32'd1);
    @(posedge clk); #1;

    // Reset during the second pass of a 15-position shift.
    do_reset();
    drive_req(1'b1, 8'h80, OP_ASR, 4'd15);
    @(negedge clk);
    check("mid ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rsp_y", 32'(rsp_y), 32'h00);
    check("mid rsp_id", 32'(rsp_id), 32'd0);
    check("mid ready0", 32'(req0_ready), 32'd0);
    check("mid ready1 idle", 32'(req1_ready), 32'd0);
    saw_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("mid no rsp", 32'(saw_rsp), 32'd0);
    @(posedge clk); #1;
    drive_req(1'b0, 8'h01, OP_LSL, 4'd1);
    drive_req(1'b1, 8'h80, OP_LSR, 4'd1);
    @(negedge clk);
    check("mid tie ready0", 32'(req0_ready), 32'd1);
    check("mid tie ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp("mid tie", n);
    check("mid tie id", 32'(rsp_id), 32'd0);
    check("mid tie y", 32'(rsp_y), 32'h02);
    @(posedge clk);
    @(negedge clk);
    check("mid next ready1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp("mid next", n);
    check("mid next id", 32'(rsp_id), 32'd1);
    check("mid next y", 32'(rsp_y), 32'h40);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
